// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one udp_send transmitter between four FWFT packet sources.
// Loads the winner's descriptor, issues one start pulse, steers payload pops and reports done/err.
module udp_tx_arbiter #(
    parameter logic [15:0] MAX_LEN      = 16'd1472,
    parameter logic [4:0]  BUSY_TIMEOUT = 5'd16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   ch_req,
    input  logic [63:0]  ch_len,
    input  logic [191:0] ch_mac,
    input  logic [127:0] ch_addr,
    input  logic [63:0]  ch_port,
    input  logic [31:0]  ch_data,
    output logic [3:0]   ch_rd,
    output logic [3:0]   ch_done,
    output logic [3:0]   ch_err,
    output logic [3:0]   grant,
    output logic         start,
    input  logic         busy,
    input  logic         tx_dv,
    output logic [7:0]   data_o,
    output logic [47:0]  dst_mac,
    output logic [31:0]  dst_addr,
    output logic [15:0]  dst_port,
    output logic [15:0]  tx_data_len,
    output logic         DF,
    output logic         MF
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  done_q, done_d;
    logic [3:0]  err_q, err_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] port_q, port_d;
    logic [15:0] len_q, len_d;
    logic [15:0] pop_cnt_q, pop_cnt_d;
    logic [4:0]  to_cnt_q, to_cnt_d;

    logic [15:0] len_a  [4];
    logic [47:0] mac_a  [4];
    logic [31:0] addr_a [4];
    logic [15:0] port_a [4];
    logic [7:0]  data_a [4];

    logic        win_found;
    logic [1:0]  win_idx;
    logic [1:0]  scan_idx;
    logic        win_len_ok;
    logic        pop;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            len_a[n]  = ch_len[16*n +: 16];
            mac_a[n]  = ch_mac[48*n +: 48];
            addr_a[n] = ch_addr[32*n +: 32];
            port_a[n] = ch_port[16*n +: 16];
            data_a[n] = ch_data[8*n +: 8];
        end
    end

    // Scan from the highest offset down so the last hit is the first requester at/after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (ch_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign win_len_ok = (len_a[win_idx] != 16'd0) && (len_a[win_idx] <= MAX_LEN);
    assign pop        = tx_dv && (pop_cnt_q < len_q);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        done_d    = 4'd0;
        err_d     = 4'd0;
        mac_d     = mac_q;
        addr_d    = addr_q;
        port_d    = port_q;
        len_d     = len_q;
        pop_cnt_d = pop_cnt_q;
        to_cnt_d  = to_cnt_q;
        start     = 1'b0;
        ch_rd     = 4'd0;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    if (!win_len_ok) begin
                        err_d    = 4'b0001 << win_idx;
                        rr_ptr_d = win_idx + 2'd1;
                    end else begin
                        grant_d   = 4'b0001 << win_idx;
                        gidx_d    = win_idx;
                        mac_d     = mac_a[win_idx];
                        addr_d    = addr_a[win_idx];
                        port_d    = port_a[win_idx];
                        len_d     = len_a[win_idx];
                        pop_cnt_d = 16'd0;
                        state_d   = S_START;
                    end
                end
            end
            S_START: begin
                start    = 1'b1;
                to_cnt_d = 5'd0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy) begin
                    state_d = S_WAIT_DONE;
                end else if (to_cnt_q == BUSY_TIMEOUT - 5'd1) begin
                    err_d    = grant_q;
                    grant_d  = 4'd0;
                    rr_ptr_d = gidx_q + 2'd1;
                    state_d  = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 5'd1;
                end
            end
            S_WAIT_DONE: begin
                // pop_cnt stops at the length, so a trailing tx_dv beat never pops
                if (pop) begin
                    ch_rd     = grant_q;
                    pop_cnt_d = pop_cnt_q + 16'd1;
                end
                if (!busy) begin
                    done_d   = grant_q;
                    grant_d  = 4'd0;
                    rr_ptr_d = gidx_q + 2'd1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= 2'd0;
            gidx_q    <= 2'd0;
            grant_q   <= 4'd0;
            done_q    <= 4'd0;
            err_q     <= 4'd0;
            mac_q     <= 48'd0;
            addr_q    <= 32'd0;
            port_q    <= 16'd0;
            len_q     <= 16'd0;
            pop_cnt_q <= 16'd0;
            to_cnt_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            mac_q     <= mac_d;
            addr_q    <= addr_d;
            port_q    <= port_d;
            len_q     <= len_d;
            pop_cnt_q <= pop_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    always_comb begin
        data_o = 8'd0;
        if (grant_q != 4'd0) begin
            data_o = data_a[gidx_q];
        end
    end

    assign grant       = grant_q;
    assign ch_done     = done_q;
    assign ch_err      = err_q;
    assign dst_mac     = mac_q;
    assign dst_addr    = addr_q;
    assign dst_port    = port_q;
    assign tx_data_len = len_q;
    assign DF          = 1'b1;
    assign MF          = 1'b0;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: a round-robin reference model predicts the event
// sequence, a udp_send model answers start, and a monitor checks every start/done/err.
module tb_udp_tx_arbiter;

    localparam int EV_START = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int          kind;
        int          ch;
        int          len;
        logic [47:0] mac;
        logic [31:0] addr;
        logic [15:0] port;
        int          gap;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_req;
    logic [63:0]  ch_len;
    logic [191:0] ch_mac;
    logic [127:0] ch_addr;
    logic [63:0]  ch_port;
    logic [31:0]  ch_data;
    logic [3:0]   ch_rd, ch_done, ch_err, grant;
    logic         start, busy, tx_dv;
    logic [7:0]   data_o;
    logic [47:0]  dst_mac;
    logic [31:0]  dst_addr;
    logic [15:0]  dst_port, tx_data_len;
    logic         DF, MF;

    logic [7:0] pay [4][4096];
    int         rd_idx [4] = '{0, 0, 0, 0};
    int         issued [4];
    int         served [4];
    int         udp_mode [4];
    int         model_ptr;
    ev_t        exp_q [$];
    int         n_tests, n_fail;
    int         multi_grant, idle_data_bad;

    always #5 clk = ~clk;

    udp_tx_arbiter dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_len(ch_len), .ch_mac(ch_mac),
        .ch_addr(ch_addr), .ch_port(ch_port), .ch_data(ch_data), .ch_rd(ch_rd),
        .ch_done(ch_done), .ch_err(ch_err), .grant(grant), .start(start), .busy(busy),
        .tx_dv(tx_dv), .data_o(data_o), .dst_mac(dst_mac), .dst_addr(dst_addr),
        .dst_port(dst_port), .tx_data_len(tx_data_len), .DF(DF), .MF(MF)
    );

    // FWFT source FIFOs: head byte is the next unread byte of each channel's stream.
    always_comb begin
        for (int n = 0; n < 4; n++) ch_data[8*n +: 8] = pay[n][rd_idx[n]];
    end

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++)
            if (ch_rd[n]) rd_idx[n] <= (rd_idx[n] + 1) % 4096;
    end

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic finish_tb();
        chk("multi_grant_cycles", 64'(multi_grant), 64'd0);
        chk("idle_data_nonzero", 64'(idle_data_bad), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    function automatic int rr_pick(int pend[4], int ptr);
        for (int k = 0; k < 4; k++)
            if (pend[(ptr + k) % 4] > 0) return (ptr + k) % 4;
        return -1;
    endfunction

    // Reference model: serve outstanding requests in round-robin order from the model pointer.
    task automatic predict();
        int pend[4];
        int w, len;
        ev_t e;
        for (int n = 0; n < 4; n++) pend[n] = issued[n] - served[n];
        w = rr_pick(pend, model_ptr);
        while (w >= 0) begin
            len    = int'(ch_len[16*w +: 16]);
            e.ch   = w;
            e.len  = len;
            e.mac  = ch_mac[48*w +: 48];
            e.addr = ch_addr[32*w +: 32];
            e.port = ch_port[16*w +: 16];
            e.gap  = -1;
            if (len == 0 || len > 1472) begin
                e.kind = EV_ERR;
                exp_q.push_back(e);
            end else begin
                e.kind = EV_START;
                exp_q.push_back(e);
                if (udp_mode[w] == 2) begin
                    e.kind = EV_ERR;
                    e.gap  = 17;
                end else begin
                    e.kind = EV_DONE;
                end
                exp_q.push_back(e);
            end
            pend[w]--;
            model_ptr = (w + 1) % 4;
            w = rr_pick(pend, model_ptr);
        end
    endtask

    task automatic setup(int n, int len, int mode);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        ch_mac[48*n +: 48]  = r[47:0];
        ch_addr[32*n +: 32] = $urandom();
        r = {$urandom(), $urandom()};
        ch_port[16*n +: 16] = r[15:0];
        ch_len[16*n +: 16]  = 16'(len);
        udp_mode[n]         = mode;
    endtask

    task automatic wait_quiet(string name, int budget);
        int  t;
        bit  quiet;
        t = 0;
        forever begin
            @(negedge clk);
            #1;
            quiet = (exp_q.size() == 0) && !busy;
            for (int n = 0; n < 4; n++) if (issued[n] != served[n]) quiet = 0;
            if (quiet) break;
            t++;
            if (t > budget) begin
                chk({"drain_", name}, 64'(exp_q.size()), 64'd0);
                finish_tb();
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic issue_and_wait(string name, int k0, int k1, int k2, int k3, int budget);
        @(posedge clk);
        #1;
        issued[0] += k0;
        issued[1] += k1;
        issued[2] += k2;
        issued[3] += k3;
        predict();
        wait_quiet(name, budget);
    endtask

    task automatic env_loop();
        int  cur_ch, pops, dbad, last_start, cyc;
        ev_t ev;
        cur_ch = 0; pops = 0; dbad = 0; last_start = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if ($countones(grant) > 1) multi_grant++;
            if (grant == 4'd0 && data_o != 8'd0) idle_data_bad++;
            if (start) begin
                chk("queue_nonempty_start", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    chk("kind_at_start", 64'(ev.kind), 64'(EV_START));
                    chk("grant_at_start", 64'(grant), 64'(4'b0001 << ev.ch));
                    chk("tx_data_len", 64'(tx_data_len), 64'(ev.len));
                    chk("dst_mac", 64'(dst_mac), 64'(ev.mac));
                    chk("dst_addr", 64'(dst_addr), 64'(ev.addr));
                    chk("dst_port", 64'(dst_port), 64'(ev.port));
                    cur_ch = ev.ch;
                end
                pops = 0; dbad = 0; last_start = cyc;
            end
            if (ch_rd != 4'd0) begin
                pops++;
                if (ch_rd != (4'b0001 << cur_ch) || data_o != pay[cur_ch][rd_idx[cur_ch]]) dbad++;
            end
            if (ch_done != 4'd0) begin
                chk("queue_nonempty_done", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    chk("kind_at_done", 64'(ev.kind), 64'(EV_DONE));
                    chk("done_onehot", 64'(ch_done), 64'(4'b0001 << ev.ch));
                    chk("pop_count", 64'(pops), 64'(ev.len));
                    chk("payload_bytes_bad", 64'(dbad), 64'd0);
                    chk("grant_after_done", 64'(grant), 64'd0);
                    chk("len_hold_after_done", 64'(tx_data_len), 64'(ev.len));
                end
            end
            if (ch_err != 4'd0) begin
                chk("queue_nonempty_err", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    chk("kind_at_err", 64'(ev.kind), 64'(EV_ERR));
                    chk("err_onehot", 64'(ch_err), 64'(4'b0001 << ev.ch));
                    chk("grant_at_err", 64'(grant), 64'd0);
                    if (ev.gap >= 0) chk("timeout_delay", 64'(cyc - last_start), 64'(ev.gap));
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (ch_done[n] || ch_err[n]) served[n]++;
                ch_req[n] = issued[n] > served[n];
            end
        end
    endtask

    task automatic udp_step(output bit ab);
        @(posedge clk);
        #1;
        ab = rst;
    endtask

    // udp_send stand-in: busy two cycles after start, tx_dv per byte (plus one in mode 1), mode 2 never busy.
    task automatic udp_loop();
        int g, mode, nd;
        bit ab;
        forever begin
            @(posedge clk);
            #1;
            if (start && !rst) begin
                g = 0;
                for (int n = 0; n < 4; n++) if (grant[n]) g = n;
                mode = udp_mode[g];
                if (mode != 2) begin
                    udp_step(ab);
                    if (!ab) udp_step(ab);
                    if (!ab) begin
                        busy = 1'b1;
                        nd = int'(tx_data_len) + ((mode == 1) ? 1 : 0);
                        for (int i = 0; i < nd && !ab; i++) begin
                            udp_step(ab);
                            if (!ab) tx_dv = 1'b1;
                        end
                        if (!ab) udp_step(ab);
                        tx_dv = 1'b0;
                        if (!ab) udp_step(ab);
                    end
                    busy  = 1'b0;
                    tx_dv = 1'b0;
                end
            end
        end
    endtask

    task automatic stim();
        int k;
        int mask, p, len;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_flags", 64'({ch_rd, ch_done, ch_err}), 64'd0);
        chk("rst_desc", 64'(dst_mac ^ {dst_addr, dst_port} ^ {32'd0, tx_data_len}), 64'd0);
        chk("rst_df_mf", 64'({DF, MF}), 64'b10);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Round-robin with ch_req kept high: order 0,1,2,3,0
        for (int n = 0; n < 4; n++) setup(n, 8, 0);
        issue_and_wait("round_robin", 2, 1, 1, 1, 400);

        // Length rejection: zero and MAX_LEN+1
        setup(1, 0, 0);
        setup(3, 1473, 0);
        issue_and_wait("length_check", 0, 1, 0, 1, 50);

        // Single packet on ch2
        setup(2, 10, 0);
        issue_and_wait("single", 0, 0, 1, 0, 100);

        // Busy timeout on ch0, then ch1 served
        setup(0, 4, 2);
        setup(1, 3, 0);
        issue_and_wait("timeout", 1, 1, 0, 0, 200);

        // Trailing tx_dv beat
        setup(3, 5, 1);
        issue_and_wait("trailing", 0, 0, 0, 1, 100);

        // Length boundaries 1 and MAX_LEN
        setup(0, 1, 0);
        setup(2, 1472, 1);
        issue_and_wait("boundary", 1, 0, 1, 0, 3000);

        // Randomized rounds
        for (int r = 0; r < 10; r++) begin
            int kk[4];
            mask = $urandom_range(1, 15);
            for (int n = 0; n < 4; n++) begin
                kk[n] = 0;
                if (mask[n]) begin
                    p = $urandom_range(0, 9);
                    if (p == 0) len = 0;
                    else if (p == 1) len = 1473 + $urandom_range(0, 200);
                    else len = $urandom_range(1, 16);
                    setup(n, len, ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1));
                    kk[n] = $urandom_range(1, 2);
                end
            end
            issue_and_wait("random", kk[0], kk[1], kk[2], kk[3], 600);
        end

        // Reset during the third pop, then ch0 has priority
        setup(2, 10, 0);
        @(posedge clk);
        #1;
        issued[2]++;
        predict();
        k = 0;
        for (int t = 0; t < 200 && k < 3; t++) begin
            @(negedge clk);
            #1;
            if (ch_rd[2]) k++;
        end
        chk("third_pop_reached", 64'(k), 64'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", 64'(grant), 64'd0);
        chk("mid_rst_flags", 64'({start, ch_rd, ch_done, ch_err}), 64'd0);
        chk("mid_rst_desc", 64'(dst_mac ^ {dst_addr, dst_port} ^ {32'd0, tx_data_len}), 64'd0);
        chk("mid_rst_data", 64'(data_o), 64'd0);
        chk("mid_rst_df_mf", 64'({DF, MF}), 64'b10);
        exp_q.delete();
        model_ptr = 0;
        setup(0, 6, 0);
        issued[0]++;
        predict();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_quiet("after_reset", 200);

        finish_tb();
    endtask

    initial begin
        rst = 1'b1;
        busy = 1'b0;
        tx_dv = 1'b0;
        ch_req = 4'd0;
        ch_len = '0;
        ch_mac = '0;
        ch_addr = '0;
        ch_port = '0;
        n_tests = 0;
        n_fail = 0;
        multi_grant = 0;
        idle_data_bad = 0;
        model_ptr = 0;
        for (int n = 0; n < 4; n++) begin
            issued[n] = 0;
            served[n] = 0;
            udp_mode[n] = 0;
            for (int i = 0; i < 4096; i++) pay[n][i] = 8'($urandom_range(1, 255));
        end
        fork
            env_loop();
            udp_loop();
            stim();
        join_any
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
